cpu_run_ctrl: RTL and testbench

- Synthesizable run controller for the MIPS core. It generalises the fixed bench sequence of reset for N cycles, run, then stop after a fixed time.
- Sequences the CPU reset, counts run cycles and detects program halt. Halt is a `j .` self-loop, i.e. PC stable.
- Watchdogs runaway programs and checks a signature register write against an expected value.
- Sits beside `CPU`, observes its PC and register-file write port, and drives the CPU's active-high reset.

---
 rtl/cpu_run_pkg.sv | 26 ++
 rtl/cpu_run_ctrl_halt_detector.sv | 59 +++++
 rtl/cpu_run_ctrl.sv | 172 +++++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_run_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_run_pkg
// Description : Shared state encoding for the CPU run controller.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_run_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] ST_RESET = 3'd1;
  localparam logic [STATE_W-1:0] ST_RUN   = 3'd2;
  localparam logic [STATE_W-1:0] ST_CHECK = 3'd3;
  localparam logic [STATE_W-1:0] ST_DONE  = 3'd4;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE  = ST_IDLE,
    S_RESET = ST_RESET,
    S_RUN   = ST_RUN,
    S_CHECK = ST_CHECK,
    S_DONE  = ST_DONE
  } run_state_e;

endpackage : cpu_run_pkg
`default_nettype wire

// File: rtl/cpu_run_ctrl_halt_detector.sv
`default_nettype none
// ============================================================================
// Module      : halt_detector
// Description : Flags a program halt (a `j .` self-loop) once the observed PC
//               has stayed unchanged for HALT_REPEAT consecutive comparisons.
// Revision    : 1.0 - initial release
// ============================================================================
module halt_detector #(
  parameter int PC_W        = 32,
  parameter int HALT_REPEAT = 4
) (
  input  logic            clk,
  input  logic            rst,    // asynchronous, active-low
  input  logic            clr,    // held high whenever the controller is not in RUN
  input  logic [PC_W-1:0] pc,
  output logic            halt
);

  localparam int SC_W = $clog2(HALT_REPEAT + 1);

  logic [PC_W-1:0] pc_prev_q, pc_prev_d;
  logic            seen_q, seen_d;      // pc_prev holds a real RUN sample
  logic [SC_W-1:0] stable_q, stable_d;
  logic            same;

  // Compare against the previous PC; the first RUN cycle has no history and
  // therefore always counts as a change.
  always_comb begin
    same      = seen_q && (pc == pc_prev_q);
    pc_prev_d = pc;
    seen_d    = 1'b1;
    stable_d  = stable_q;
    if (clr) begin
      pc_prev_d = '0;
      seen_d    = 1'b0;
      stable_d  = '0;
    end else if (!same) begin
      stable_d  = '0;
    end else if (stable_q != SC_W'(HALT_REPEAT)) begin
      stable_d  = stable_q + 1'b1;
    end
    halt = !clr && same && (stable_d == SC_W'(HALT_REPEAT));
  end

  // PC history and stability counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_prev_q <= '0;
      seen_q    <= 1'b0;
      stable_q  <= '0;
    end else begin
      pc_prev_q <= pc_prev_d;
      seen_q    <= seen_d;
      stable_q  <= stable_d;
    end
  end

endmodule : halt_detector
`default_nettype wire

// File: rtl/cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cpu_run_ctrl
// Description : Run controller for the MIPS core. Holds the CPU in reset,
//               runs it, detects halt or watchdog expiry and checks the
//               signature register against an expected value.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_run_ctrl
  import cpu_run_pkg::*;
#(
  parameter int PC_W        = 32,
  parameter int RST_CYCLES  = 2,
  parameter int MAX_CYCLES  = 50,
  parameter int HALT_REPEAT = 4,
  parameter int SIG_REG     = 2,
  parameter int CNT_W       = $clog2(MAX_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             rst,          // asynchronous, active-low
  input  logic             start,
  input  logic             abort,
  input  logic [PC_W-1:0]  pc,
  input  logic             reg_we,
  input  logic [4:0]       reg_waddr,
  input  logic [31:0]      reg_wdata,
  input  logic [31:0]      expected,
  output logic             cpu_rst,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  run_state_e       state_q, state_d;
  logic [RC_W-1:0]  rst_cnt_q, rst_cnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  logic             pass_q, pass_d;
  logic [31:0]      sig_q, sig_d;
  logic             sig_valid_q, sig_valid_d;
  logic [31:0]      exp_q, exp_d;
  logic             cpu_rst_q, cpu_rst_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             halt;
  logic             halt_clr;
  logic             sig_write;

  assign halt_clr  = (state_q != S_RUN);
  assign sig_write = reg_we && (reg_waddr == 5'(SIG_REG));

  halt_detector #(
    .PC_W        (PC_W),
    .HALT_REPEAT (HALT_REPEAT)
  ) u_halt_detector (
    .clk  (clk),
    .rst  (rst),
    .clr  (halt_clr),
    .pc   (pc),
    .halt (halt)
  );

  // Next-state and next-output logic for the run sequence.
  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
    cnt_d       = cnt_q;
    timeout_d   = timeout_q;
    pass_d      = pass_q;
    sig_d       = sig_q;
    sig_valid_d = sig_valid_q;
    exp_d       = exp_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        // A new run always starts from clean result flags.
        if (start) begin
          state_d     = S_RESET;
          rst_cnt_d   = '0;
          cnt_d       = '0;
          timeout_d   = 1'b0;
          pass_d      = 1'b0;
          sig_valid_d = 1'b0;
        end
      end
      S_RESET: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (rst_cnt_q == RC_W'(RST_CYCLES - 1)) begin
          state_d = S_RUN;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        if (cnt_q != CNT_W'(MAX_CYCLES)) begin
          cnt_d = cnt_q + 1'b1;
        end
        // The write is captured even on the edge that ends the run.
        if (sig_write) begin
          sig_d       = reg_wdata;
          sig_valid_d = 1'b1;
        end
        if (abort) begin
          state_d = S_IDLE;
        end else if (halt) begin
          state_d = S_CHECK;
          exp_d   = expected;
        end else if (cnt_q == CNT_W'(MAX_CYCLES - 1)) begin
          state_d   = S_CHECK;
          timeout_d = 1'b1;
          exp_d     = expected;
        end
      end
      S_CHECK: begin
        pass_d  = sig_valid_q && !timeout_q && (sig_q == exp_q);
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered from the state being entered.
    cpu_rst_d = (state_d == S_IDLE) || (state_d == S_RESET);
    busy_d    = (state_d == S_RESET) || (state_d == S_RUN) || (state_d == S_CHECK);
    done_d    = (state_d == S_DONE);
  end

  // State, counters, captured signature and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      rst_cnt_q   <= '0;
      cnt_q       <= '0;
      timeout_q   <= 1'b0;
      pass_q      <= 1'b0;
      sig_q       <= '0;
      sig_valid_q <= 1'b0;
      exp_q       <= '0;
      cpu_rst_q   <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      cnt_q       <= cnt_d;
      timeout_q   <= timeout_d;
      pass_q      <= pass_d;
      sig_q       <= sig_d;
      sig_valid_q <= sig_valid_d;
      exp_q       <= exp_d;
      cpu_rst_q   <= cpu_rst_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign cpu_rst     = cpu_rst_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign timeout     = timeout_q;
  assign cycle_count = cnt_q;

endmodule : cpu_run_ctrl
`default_nettype wire

// File: tb/tb_cpu_run_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_cpu_run_ctrl
// Description : Self-checking bench for cpu_run_ctrl with a simple CPU stub
//               and a cycle-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_run_ctrl;

  localparam int PC_W        = 32;
  localparam int RST_CYCLES  = 2;
  localparam int MAX_CYCLES  = 50;
  localparam int HALT_REPEAT = 4;
  localparam int SIG_REG     = 2;
  localparam int CNT_W       = $clog2(MAX_CYCLES + 1);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [PC_W-1:0]  pc = '0;
  logic             reg_we = 1'b0;
  logic [4:0]       reg_waddr = '0;
  logic [31:0]      reg_wdata = '0;
  logic [31:0]      expected = '0;
  logic             cpu_rst, busy, done, pass, timeout;
  logic [CNT_W-1:0] cycle_count;

  always #5 clk = ~clk;

  cpu_run_ctrl #(
    .PC_W        (PC_W),
    .RST_CYCLES  (RST_CYCLES),
    .MAX_CYCLES  (MAX_CYCLES),
    .HALT_REPEAT (HALT_REPEAT),
    .SIG_REG     (SIG_REG),
    .CNT_W       (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst_n),
    .start       (start),
    .abort       (abort),
    .pc          (pc),
    .reg_we      (reg_we),
    .reg_waddr   (reg_waddr),
    .reg_wdata   (reg_wdata),
    .expected    (expected),
    .cpu_rst     (cpu_rst),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .timeout     (timeout),
    .cycle_count (cycle_count)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  localparam int P_IDLE = 0, P_RESET = 1, P_RUN = 2, P_CHECK = 3, P_DONE = 4;
  int              m_phase = P_IDLE;
  int              m_rleft = 0;
  int              m_cnt   = 0;
  bit              m_to    = 0;
  bit              m_pass  = 0;
  bit              m_sv    = 0;
  bit              m_halted;
  logic [31:0]     m_sig = '0;
  logic [31:0]     m_exp = '0;
  logic [PC_W-1:0] m_hist[$];

  // Halt = the last HALT_REPEAT+1 PC samples of this run are all identical.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = P_IDLE;
      m_cnt   = 0;
      m_to    = 0;
      m_pass  = 0;
      m_sv    = 0;
      m_hist.delete();
    end else begin
      case (m_phase)
        P_IDLE, P_DONE: if (start) begin
          m_phase = P_RESET;
          m_rleft = RST_CYCLES;
          m_cnt   = 0;
          m_to    = 0;
          m_pass  = 0;
          m_sv    = 0;
        end
        P_RESET: begin
          if (abort) m_phase = P_IDLE;
          else begin
            m_rleft--;
            if (m_rleft == 0) begin
              m_phase = P_RUN;
              m_hist.delete();
            end
          end
        end
        P_RUN: begin
          m_hist.push_back(pc);
          m_halted = 0;
          if (m_hist.size() >= HALT_REPEAT + 1) begin
            m_halted = 1;
            for (int i = 1; i <= HALT_REPEAT; i++)
              if (m_hist[m_hist.size() - 1 - i] != pc) m_halted = 0;
          end
          if (reg_we && reg_waddr == SIG_REG) begin
            m_sig = reg_wdata;
            m_sv  = 1;
          end
          if (m_cnt < MAX_CYCLES) m_cnt++;
          if (abort) m_phase = P_IDLE;
          else if (m_halted) begin
            m_phase = P_CHECK;
            m_exp   = expected;
          end else if (m_cnt == MAX_CYCLES) begin
            m_phase = P_CHECK;
            m_to    = 1;
            m_exp   = expected;
          end
        end
        P_CHECK: begin
          m_pass  = m_sv && !m_to && (m_sig == m_exp);
          m_phase = P_DONE;
        end
        default: m_phase = P_IDLE;
      endcase
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    check("cpu_rst", cpu_rst, (m_phase == P_IDLE) || (m_phase == P_RESET));
    check("busy", busy, (m_phase == P_RESET) || (m_phase == P_RUN) || (m_phase == P_CHECK));
    check("done", done, m_phase == P_DONE);
    check("cycle_count", cycle_count, m_cnt);
    if (m_phase == P_DONE) begin
      check("pass", pass, m_pass);
      check("timeout", timeout, m_to);
    end
  end

  // ---------------- CPU stub and stimulus ----------------
  int          k = 0;        // RUN cycle number seen by the CPU (0 while held in reset)
  int          halt_at = 0;  // PC freezes at 0x20 from this cycle (0 = never)
  int          w1_at = 0, w2_at = 0;
  logic [31:0] w1_val = '0, w2_val = '0;
  int          abort_at = 0;
  bit          start_on_abort = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    if (cpu_rst) k = 0;
    else k++;
    pc        = (halt_at != 0 && k >= halt_at) ? 32'h20 : 32'h100 + 32'(4 * k);
    reg_we    = 1'b0;
    reg_waddr = '0;
    reg_wdata = '0;
    if (k == 4) begin
      reg_we = 1'b1; reg_waddr = 5'(SIG_REG + 1); reg_wdata = 32'hDEAD;
    end
    if (k != 0 && k == w1_at) begin
      reg_we = 1'b1; reg_waddr = 5'(SIG_REG); reg_wdata = w1_val;
    end
    if (k != 0 && k == w2_at) begin
      reg_we = 1'b1; reg_waddr = 5'(SIG_REG); reg_wdata = w2_val;
    end
    abort = (abort_at != 0 && k == abort_at);
    if (start_on_abort) start = abort;
  endtask

  task automatic run_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 200) begin
      tick();
      n++;
    end
    check({name, " reached done"}, done, 1);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    check({name, " left busy"}, busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global time limit: got running, required finished");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n = 1'b0;
    repeat (3) tick();
    check("reset cpu_rst", cpu_rst, 1);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset pass", pass, 0);
    check("reset timeout", timeout, 0);
    check("reset cycle_count", cycle_count, 0);
    rst_n = 1'b1;
    repeat (2) tick();
    check("idle without start", busy, 0);

    // Halt with correct signature
    halt_at = 8; w1_at = 5; w1_val = 32'h2A; expected = 32'h2A;
    run_start();
    n = 0;
    while (cpu_rst && busy && n < 20) begin
      n++;
      tick();
    end
    check("s1 reset hold cycles", n, 2);
    wait_done("s1");
    check("s1 cycle_count", cycle_count, 12);
    check("s1 pass", pass, 1);
    check("s1 timeout", timeout, 0);
    check("s1 cpu_rst in done", cpu_rst, 0);

    // Wrong signature
    expected = 32'h2B;
    run_start();
    wait_done("s2");
    check("s2 pass", pass, 0);
    check("s2 timeout", timeout, 0);
    check("s2 cycle_count", cycle_count, 12);

    // Watchdog: PC never settles; a correct signature cannot rescue it
    halt_at = 0; expected = 32'h2A;
    run_start();
    wait_done("s3");
    check("s3 timeout", timeout, 1);
    check("s3 pass", pass, 0);
    check("s3 cycle_count", cycle_count, 50);

    // No signature write (only R3 is written, with the expected value)
    halt_at = 8; w1_at = 0; expected = 32'hDEAD;
    run_start();
    check("s4 restart clears timeout", timeout, 0);
    check("s4 restart clears cycle_count", cycle_count, 0);
    wait_done("s4a");
    check("s4a pass", pass, 0);
    check("s4a cycle_count", cycle_count, 12);

    // Last write wins
    w1_at = 3; w1_val = 32'h1; w2_at = 6; w2_val = 32'h2A; expected = 32'h2A;
    run_start();
    wait_done("s4b");
    check("s4b pass", pass, 1);

    // Abort in RUN cycle 3
    abort_at = 3;
    run_start();
    check("s5 restart clears pass", pass, 0);
    wait_idle("s5");
    check("s5 cpu_rst", cpu_rst, 1);
    check("s5 done", done, 0);
    check("s5 cycle_count", cycle_count, 3);
    check("s5 pass", pass, 0);
    check("s5 timeout", timeout, 0);
    repeat (3) tick();
    check("s5 stays idle", busy, 0);

    // Abort and start together: abort wins
    start_on_abort = 1;
    run_start();
    wait_idle("s6");
    check("s6 cycle_count", cycle_count, 3);
    tick();
    check("s6 abort beats start", busy, 0);
    check("s6 cpu_rst", cpu_rst, 1);
    start_on_abort = 0; abort_at = 0;

    // Asynchronous reset mid-run
    run_start();
    repeat (6) tick();
    check("s7 in run", busy && !cpu_rst, 1);
    #2 rst_n = 1'b0;
    #1;
    check("s7 async cpu_rst", cpu_rst, 1);
    check("s7 async busy", busy, 0);
    check("s7 async cycle_count", cycle_count, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("s7 needs start", busy, 0);
    run_start();
    wait_done("s7");
    check("s7 pass", pass, 1);
    check("s7 cycle_count", cycle_count, 12);

    tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_cpu_run_ctrl
`default_nettype wire
